// File: rtl/ram_arbiter.sv
// Two-client round-robin front end for a 64x8 synchronous RAM; read data comes back one cycle after acceptance.
// Define RAM_ARB_CLEAR_EN to zero-fill the RAM after every reset before any request is accepted.
module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_done
);

  logic [1:0] req_valid;
  logic [1:0] req_we;
  logic [1:0] ready;
  logic [1:0] rsp_valid_reg;
  logic       in_run;
  logic       grant_any;
  logic       grant_sel;
  logic       accept;
  logic       last_grant_reg;

  assign req_valid = {req1_valid, req0_valid};
  assign req_we    = {req1_we, req0_we};

`ifdef RAM_ARB_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;

  // Leave CLEAR right after the edge that writes the last address.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    if (state_reg == ST_CLEAR) begin
      clr_addr_next = clr_addr_reg + 1'b1;
      if (&clr_addr_reg) state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  assign in_run = (state_reg == ST_RUN);
`else
  assign in_run = 1'b1;
`endif

  assign init_done = in_run;

  // On a tie the client that did not win the last accepted transfer goes first.
  always_comb begin
    grant_sel = 1'b0;
    case (req_valid)
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant_reg;
      default: grant_sel = 1'b0;
    endcase
  end

  assign grant_any  = |req_valid;
  assign accept     = in_run && grant_any;
  assign ready      = {accept && grant_sel, accept && !grant_sel};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_comb begin
    ram_we         = 1'b0;
    ram_write_addr = '0;
    ram_read_addr  = '0;
    ram_data       = '0;
    if (accept) begin
      ram_we         = grant_sel ? req1_we    : req0_we;
      ram_write_addr = grant_sel ? req1_addr  : req0_addr;
      ram_read_addr  = grant_sel ? req1_addr  : req0_addr;
      ram_data       = grant_sel ? req1_wdata : req0_wdata;
    end
`ifdef RAM_ARB_CLEAR_EN
    if (!in_run) begin
      ram_we         = 1'b1;
      ram_write_addr = clr_addr_reg;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      rsp_valid_reg  <= 2'b00;
    end else begin
      if (accept) last_grant_reg <= grant_sel;
      rsp_valid_reg <= ready & ~req_we;
    end
  end

  // ram_q is only meaningful in the cycle after an accepted read.
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp0_rdata = rsp_valid_reg[0] ? ram_q : '0;
  assign rsp1_rdata = rsp_valid_reg[1] ? ram_q : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a behavioural RAM environment, a reference model predicting grants,
// RAM contents and read responses, and a monitor that checks responses as the DUT presents them.
module tb_ram_arbiter;

  typedef struct {
    logic       v;
    logic       we;
    logic [5:0] a;
    logic [7:0] d;
  } req_t;

  typedef struct {
    int         client;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [5:0] req0_addr = '0;
  logic [7:0] req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [5:0] req1_addr = '0;
  logic [7:0] req1_wdata = '0;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic       ram_we;
  logic [5:0] ram_write_addr, ram_read_addr;
  logic [7:0] ram_data;
  logic [7:0] ram_q = 8'h00;
  logic       init_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] model_mem [64];
  int         model_last = 1;
  exp_t       exp_q [$];
  exp_t       mon_e;

  // Behavioural RAM the arbiter drives, with deliberately non-zero power-up contents
  logic [7:0] mem [64] = '{default: 8'hEE};

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
    .ram_data(ram_data), .ram_q(ram_q), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp0_valid=%0b rsp1_valid=%0b, expected no response (cycle %0d)",
                   rsp0_valid, rsp1_valid, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_cycle", cyc, mon_e.due);
          check("rsp0_valid", int'(rsp0_valid), int'(mon_e.client == 0));
          check("rsp1_valid", int'(rsp1_valid), int'(mon_e.client == 1));
          check("rsp0_rdata", int'(rsp0_rdata), (mon_e.client == 0) ? int'(mon_e.data) : 0);
          check("rsp1_rdata", int'(rsp1_rdata), (mon_e.client == 1) ? int'(mon_e.data) : 0);
          $display("rsp  cycle %0d client %0d data 0x%02h", cyc, mon_e.client,
                   (mon_e.client == 0) ? rsp0_rdata : rsp1_rdata);
        end
      end else begin
        check("rsp0_rdata_idle", int'(rsp0_rdata), 0);
        check("rsp1_rdata_idle", int'(rsp1_rdata), 0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          mon_e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_rsp: no rsp_valid, expected client %0d data 0x%02h (cycle %0d)",
                   mon_e.client, mon_e.data, cyc);
        end
      end
    end
  end

  // Drive one cycle of requests and predict the arbiter's reaction from the round-robin rules.
  task automatic drive(input req_t r0, input req_t r1, output int gnt);
    req_t g;
    req0_valid = r0.v; req0_we = r0.we; req0_addr = r0.a; req0_wdata = r0.d;
    req1_valid = r1.v; req1_we = r1.we; req1_addr = r1.a; req1_wdata = r1.d;
    #1;
    gnt = -1;
    if (r0.v && r1.v) gnt = (model_last == 1) ? 0 : 1;
    else if (r0.v)    gnt = 0;
    else if (r1.v)    gnt = 1;
    check("req0_ready", int'(req0_ready), int'(gnt == 0));
    check("req1_ready", int'(req1_ready), int'(gnt == 1));
    if (gnt >= 0) begin
      g = (gnt == 0) ? r0 : r1;
      check("ram_we", int'(ram_we), int'(g.we));
      check("ram_write_addr", int'(ram_write_addr), int'(g.a));
      check("ram_read_addr", int'(ram_read_addr), int'(g.a));
      check("ram_data", int'(ram_data), int'(g.d));
      model_last = gnt;
      if (g.we) begin
        model_mem[g.a] = g.d;
      end else begin
        exp_q.push_back('{gnt, model_mem[g.a], cyc + 1});
      end
      $display("req  cycle %0d client %0d %s addr %0d data 0x%02h", cyc, gnt,
               g.we ? "write" : "read ", g.a, g.d);
    end else begin
      check("ram_we_idle", int'(ram_we), 0);
      check("ram_addr_idle", int'(ram_write_addr) + int'(ram_read_addr), 0);
      check("ram_data_idle", int'(ram_data), 0);
    end
  endtask

  task automatic step(input req_t r0, input req_t r1, output int gnt);
    drive(r0, r1, gnt);
    @(negedge clk);
  endtask

  function automatic req_t mk(input logic v, input logic we, input int a, input int d);
    req_t r;
    r.v = v; r.we = we; r.a = 6'(a); r.d = 8'(d);
    return r;
  endfunction

  task automatic apply_reset();
    req_t idle;
    int   g;
    idle = mk(1'b0, 1'b0, 0, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_rsp0_valid", int'(rsp0_valid), 0);
    check("reset_rsp1_valid", int'(rsp1_valid), 0);
    check("reset_rsp_rdata", int'(rsp0_rdata) + int'(rsp1_rdata), 0);
    check("reset_ready", int'(req0_ready) + int'(req1_ready), 0);
    check("reset_ram_addr", int'(ram_write_addr) + int'(ram_read_addr), 0);
    check("reset_ram_data", int'(ram_data), 0);
`ifdef RAM_ARB_CLEAR_EN
    check("reset_init_done", int'(init_done), 0);
    check("reset_ram_we", int'(ram_we), 1);
`else
    check("reset_init_done", int'(init_done), 1);
    check("reset_ram_we", int'(ram_we), 0);
`endif
    exp_q.delete();
    model_last = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("rst  cycle %0d reset released", cyc);
`ifdef RAM_ARB_CLEAR_EN
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    req0_valid = 1'b1;
    req0_addr  = 6'd7;
    for (int k = 0; k < 64; k++) begin
      #1;
      check("clear_ready0", int'(req0_ready), 0);
      check("clear_init_done", int'(init_done), 0);
      check("clear_ram_we", int'(ram_we), 1);
      check("clear_addr", int'(ram_write_addr), k);
      check("clear_data", int'(ram_data), 0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    #1;
    check("init_done_after_clear", int'(init_done), 1);
`else
    #1;
    check("init_done", int'(init_done), 1);
    for (int k = 0; k < 64; k++) step(mk(1'b1, 1'b1, k, k * 37 + 11), idle, g);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t idle, p0, p1;
    int   g;
    idle = mk(1'b0, 1'b0, 0, 0);
    #2;
    apply_reset();

    // First tie after reset: both clients write address 9
    step(mk(1'b1, 1'b1, 9, 8'h01), mk(1'b1, 1'b1, 9, 8'h02), g);
    step(idle, mk(1'b1, 1'b1, 9, 8'h02), g);
    step(mk(1'b1, 1'b0, 9, 0), idle, g);

    // Post-reset contents at the ends and middle of the address range
    step(mk(1'b1, 1'b0, 0, 0), idle, g);
    step(mk(1'b1, 1'b0, 31, 0), idle, g);
    step(mk(1'b1, 1'b0, 63, 0), idle, g);

    // Write then read the same address on consecutive cycles
    step(mk(1'b1, 1'b1, 5, 8'hA5), idle, g);
    step(mk(1'b1, 1'b0, 5, 0), idle, g);

    // Continuous contention on reads
    step(mk(1'b1, 1'b1, 1, 8'h11), idle, g);
    step(idle, mk(1'b1, 1'b1, 2, 8'h22), g);
    for (int i = 0; i < 4; i++) step(mk(1'b1, 1'b0, 1, 0), mk(1'b1, 1'b0, 2, 0), g);

    // Idle stretch
    for (int i = 0; i < 20; i++) step(idle, idle, g);

    // Randomized traffic; each client holds its request until the model says it was accepted
    p0 = idle;
    p1 = idle;
    for (int n = 0; n < 400; n++) begin
      if (!p0.v && $urandom_range(3) != 0)
        p0 = mk(1'b1, 1'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(255)));
      if (!p1.v && $urandom_range(3) != 0)
        p1 = mk(1'b1, 1'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(255)));
      step(p0, p1, g);
      if (g == 0) p0.v = 1'b0;
      else if (g == 1) p1.v = 1'b0;
    end
    step(idle, idle, g);

    // Reset asserted the cycle after a read is accepted
    drive(mk(1'b1, 1'b0, 5, 0), idle, g);
    @(posedge clk);
    #1;
    check("rsp0_valid_before_reset", int'(rsp0_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rsp0_valid_at_reset", int'(rsp0_valid), 0);
    check("rsp0_rdata_at_reset", int'(rsp0_rdata), 0);
    apply_reset();
    step(mk(1'b1, 1'b0, 5, 0), idle, g);
    step(mk(1'b1, 1'b0, 0, 0), mk(1'b1, 1'b0, 63, 0), g);
    step(mk(1'b1, 1'b0, 0, 0), idle, g);
    step(idle, idle, g);
    step(idle, idle, g);

    check("pending_responses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin controller for the single-clock 64x8 synchronous RAM. It arbitrates read/write requests from two independent clients onto the RAM's single write/read port set and returns read data with a fixed one-cycle latency. It optionally zero-fills the whole RAM after reset. It sits between the RAM instance and its clients; the RAM itself stays a separate instance.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH

Ports (N = 0, 1):
- clk  in  1  rising-edge clock, shared with the RAM
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  client N request present
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  request address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_ready  out  1  request accepted this cycle (combinational)
- rspN_valid  out  1  read data valid for client N (registered)
- rspN_rdata  out  DATA_WIDTH  read data; ram_q when rspN_valid, else 0
- ram_we  out  1  RAM write enable
- ram_write_addr  out  ADDR_WIDTH  RAM write address
- ram_read_addr  out  ADDR_WIDTH  RAM read address
- ram_data  out  DATA_WIDTH  RAM write data
- ram_q  in  DATA_WIDTH  RAM registered read data (q = ram[read_addr] one edge after)
- init_done  out  1  1 once the controller is in RUN

## Operation
- States:
  - CLEAR: only with RAM_ARB_CLEAR_EN; zero-fills the RAM.
  - RUN: normal arbitration.
- CLEAR:
  - 6-bit counter clr_addr starts at 0.
  - Each cycle drives ram_we=1, ram_write_addr=clr_addr, ram_data=0.
  - After writing address 63, goes to RUN.
  - Both readys are 0 throughout.
- RUN, arbitration:
  - Only one valid request: that client is granted.
  - Both valid: grant the client that is not last_grant.
  - last_grant resets to 1, so client 0 wins the first tie.
  - last_grant updates only on an accepted transfer (valid && ready).
  - reqN_ready = RUN && grant==N. Ready may depend on the other client's valid.
  - A client must hold valid and its fields stable until ready.
- RUN, RAM drive:
  - Granted request drives ram_write_addr = ram_read_addr = reqN_addr, ram_data = reqN_wdata, ram_we = reqN_we, all combinationally.
  - No grant: ram_we=0, addresses 0, data 0.
- Read response:
  - An accepted read sets rspN_valid for exactly the next cycle.
  - rspN_rdata = ram_q in that cycle.
  - Accepted writes produce no response.
- Only one RAM operation happens per cycle, so there is no same-cycle read/write collision.
  - A write at T followed by a read of the same address at T+1 returns the new data.

## Timing
- Reset values:
  - reqN_ready=0, rspN_valid=0, rspN_rdata=0.
  - ram_data=0, ram_write_addr=0, ram_read_addr=0.
  - init_done=0 with RAM_ARB_CLEAR_EN, 1 without.
  - ram_we=0 in RUN; 1 in CLEAR (the reset state when RAM_ARB_CLEAR_EN is defined).
  - last_grant=1, clr_addr=0.
- Read latency: accept in cycle T gives rspN_valid=1 and data in cycle T+1.
- Throughput: one transfer per cycle. Back-to-back reads give continuous rspN_valid.
- Under continuous contention, the two clients alternate every cycle.
- CLEAR lasts exactly 64 cycles after reset release. init_done rises in cycle 65; the first acceptance is possible in that cycle.
- Reset asserted mid-operation:
  - Immediately clears rsp valids and drops any in-flight read.
  - Restarts CLEAR from address 0 when RAM_ARB_CLEAR_EN is defined.

## Configuration
- RAM_ARB_CLEAR_EN defined:
  - CLEAR state and clr_addr counter are present.
  - The RAM reads 0 at every address after reset.
- RAM_ARB_CLEAR_EN undefined:
  - No CLEAR logic; the reset state is RUN and init_done is tied to 1.
  - RAM contents after reset are undefined.

## Test plan
- Clear on reset (macro on): release rst_n, wait until init_done=1, read addresses 0, 31, 63 -> each rsp0_rdata=0x00; readys 0 for the first 64 cycles.
- Single-client write/read: req0 writes 0xA5 to addr 5, then reads addr 5 on the next cycle -> rsp0_valid=1 one cycle after the read is accepted, rsp0_rdata=0xA5.
- Contention: both clients hold valid reads (c0 addr 1 = 0x11, c1 addr 2 = 0x22) for 4 cycles -> grants alternate 0,1,0,1; responses alternate 0x11 and 0x22, one cycle after each grant.
- Write fairness: both clients write to addr 9 (c0 0x01, c1 0x02) in the same cycle, first tie after reset -> c0 accepted first, c1 next cycle; a later read of addr 9 returns 0x02.
- Reset mid-stream: assert rst_n low the cycle after a read is accepted -> rsp0_valid=0 immediately; with the macro, CLEAR restarts and the RAM reads 0 afterwards.
- Idle: no valid requests -> ram_we=0, both readys 0, no rsp_valid for 20 cycles.
